// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO controller.
//   - Region encodings: the 3-bit field above the channel index in the window offset.
//   - Load/store width encodings: RISC-V funct3 values.
//   - lane_mask: byte lanes a B/H/W access enables. Returns 0 for misaligned or unsupported widths.
//   - byte_mask: expands 4 lane enables into a 32-bit bit mask.
//   - load_ext:  sign or zero extension of a right-aligned load value.
package gpio_pkg;

    localparam logic [2:0] REG_OUT = 3'd0;
    localparam logic [2:0] REG_SET = 3'd1;
    localparam logic [2:0] REG_CLR = 3'd2;
    localparam logic [2:0] REG_IN  = 3'd3;
    localparam logic [2:0] REG_EVT = 3'd4;

    localparam logic [2:0] LEN_B  = 3'd0;
    localparam logic [2:0] LEN_H  = 3'd1;
    localparam logic [2:0] LEN_W  = 3'd2;
    localparam logic [2:0] LEN_BU = 3'd4;
    localparam logic [2:0] LEN_HU = 3'd5;

    function automatic logic [3:0] lane_mask(input logic [2:0] len, input logic [1:0] ofs);
        logic [3:0] m;
        m = 4'b0000;
        case (len)
            LEN_B, LEN_BU: m = 4'b0001 << ofs;
            LEN_H, LEN_HU: begin
                if (!ofs[0]) m = ofs[1] ? 4'b1100 : 4'b0011;
            end
            LEN_W: begin
                if (ofs == 2'b00) m = 4'b1111;
            end
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] len, input logic [31:0] v);
        logic [31:0] r;
        case (len)
            LEN_B:   r = {{24{v[7]}}, v[7:0]};
            LEN_BU:  r = {24'h0, v[7:0]};
            LEN_H:   r = {{16{v[15]}}, v[15:0]};
            LEN_HU:  r = {16'h0, v[15:0]};
            LEN_W:   r = v;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Input synchroniser plus rising-edge detector for one GPIO channel.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input bits
//   level_o : synchronised level (Stages edges after d_i)
//   rise_o  : one-cycle pulse per bit on a 0->1 transition of level_o
module gpio_in_sync #(
    parameter int unsigned Width  = 32,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] level_o,
    output logic [Width-1:0] rise_o
);

    // Index 0 captures the raw input; index Stages-1 is the settled value.
    logic [Stages-1:0][Width-1:0] sync_q;
    logic [Width-1:0]             prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    // prev_q resets to 0, so an input already high at reset release yields one rise.
    assign level_o = sync_q[Stages-1];
    assign rise_o  = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO controller decoding MEM-stage loads/stores in a window at BASE_ADDR.
//   clk, rst_n            : clock, asynchronous active-low reset
//   addr, wdata, len      : byte address, right-aligned store data, RISC-V funct3 width
//   rd_en, wr_en          : load / store strobes
//   hit                   : addr falls inside the window (combinational)
//   rdata                 : extended load data, 0 unless rd_en & hit
//   io_in / io_out        : per-channel asynchronous inputs / registered outputs
//   irq                   : OR of all sticky event bits
// Offset layout: {region[2:0], channel[log2 NUM_CH-1:0], byte[1:0]}.
module mmio_gpio
    import gpio_pkg::*;
#(
    parameter int unsigned        WIDTH       = 32,
    parameter int unsigned        BASE_ADDR   = 256,
    parameter int unsigned        NUM_CH      = 4,
    parameter int unsigned        IO_WIDTH    = 32,
    parameter logic [IO_WIDTH-1:0] OUT_RESET  = '0,
    parameter int unsigned        SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           addr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [2:0]                 len,
    input  logic                       rd_en,
    input  logic                       wr_en,
    output logic                       hit,
    output logic [WIDTH-1:0]           rdata,
    input  logic [NUM_CH*IO_WIDTH-1:0] io_in,
    output logic [NUM_CH*IO_WIDTH-1:0] io_out,
    output logic                       irq
);

    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned OffW = 5 + $clog2(NUM_CH);
    localparam logic [31:0] IoMask = (IO_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'h1 << IO_WIDTH) - 32'h1);
    localparam logic [WIDTH-1:0] BaseAddr = WIDTH'(BASE_ADDR);

    logic [NUM_CH-1:0][IO_WIDTH-1:0] out_q, out_d;
    logic [NUM_CH-1:0][IO_WIDTH-1:0] evt_q, evt_d;
    logic [NUM_CH-1:0][IO_WIDTH-1:0] in_lvl, in_rise;

    logic [2:0]      region;
    logic [IdxW-1:0] idx;
    logic [3:0]      lanes;
    logic [31:0]     bmask;
    logic [31:0]     wd_al;
    logic [31:0]     wd_m;
    logic            wr_ok;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;

    // ---------------------------------------------------------------- input channels
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gpio_in_sync #(
            .Width  (IO_WIDTH),
            .Stages (SYNC_STAGES)
        ) u_sync (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .d_i     (io_in[g*IO_WIDTH +: IO_WIDTH]),
            .level_o (in_lvl[g]),
            .rise_o  (in_rise[g])
        );
    end

    // ---------------------------------------------------------------- decode
    assign hit    = (addr >> OffW) == (BaseAddr >> OffW);
    assign region = addr[OffW-1 -: 3];
    assign idx    = (NUM_CH > 1) ? IdxW'(addr >> 2) : '0;
    assign lanes  = lane_mask(len, addr[1:0]);
    // Bits at or above IO_WIDTH are never writable.
    assign bmask  = byte_mask(lanes) & IoMask;

    always_comb begin
        wd_al = wdata[31:0];
        case (len[1:0])
            2'b00:   wd_al = {4{wdata[7:0]}};
            2'b01:   wd_al = {2{wdata[15:0]}};
            default: wd_al = wdata[31:0];
        endcase
    end

    assign wd_m  = wd_al & bmask;
    assign wr_ok = wr_en & hit & (lanes != 4'b0000);

    // ---------------------------------------------------------------- register next state
    always_comb begin
        out_d = out_q;
        // Rising edges OR in after any W1C so a coincident set wins.
        evt_d = evt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok && (idx == IdxW'(i))) begin
                case (region)
                    REG_OUT: out_d[i] = (out_q[i] & ~IO_WIDTH'(bmask)) | IO_WIDTH'(wd_m);
                    REG_SET: out_d[i] = out_q[i] | IO_WIDTH'(wd_m);
                    REG_CLR: out_d[i] = out_q[i] & ~IO_WIDTH'(wd_m);
                    REG_EVT: evt_d[i] = evt_q[i] & ~IO_WIDTH'(wd_m);
                    default: ;
                endcase
            end
            evt_d[i] = evt_d[i] | in_rise[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {NUM_CH{OUT_RESET}};
            evt_q <= '0;
        end else begin
            out_q <= out_d;
            evt_q <= evt_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign io_out = out_q;
    assign irq    = |evt_q;

    always_comb begin
        rd_word = 32'h0;
        case (region)
            REG_OUT, REG_SET, REG_CLR: rd_word = 32'(out_q[idx]);
            REG_IN:                    rd_word = 32'(in_lvl[idx]);
            REG_EVT:                   rd_word = 32'(evt_q[idx]);
            default:                   rd_word = 32'h0;
        endcase
    end

    assign rd_shift = rd_word >> {addr[1:0], 3'b000};
    // lanes == 0 covers misaligned and unsupported widths.
    assign rdata = (rd_en && hit && (lanes != 4'b0000)) ? WIDTH'(load_ext(len, rd_shift))
                                                        : '0;

endmodule

// File: tb/tb_mmio_gpio.sv
module tb_mmio_gpio;

    localparam int unsigned NCH = 8;
    localparam int unsigned IOW = 32;

    logic              clk;
    logic              rst_n;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [2:0]        len;
    logic              rd_en;
    logic              wr_en;
    logic              hit;
    logic [31:0]       rdata;
    logic [NCH*IOW-1:0] io_in;
    logic [NCH*IOW-1:0] io_out;
    logic              irq;

    int n_cmp;
    int n_fail;

    mmio_gpio #(
        .WIDTH       (32),
        .BASE_ADDR   (256),
        .NUM_CH      (NCH),
        .IO_WIDTH    (IOW),
        .OUT_RESET   (32'hA5),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wdata  (wdata),
        .len    (len),
        .rd_en  (rd_en),
        .wr_en  (wr_en),
        .hit    (hit),
        .rdata  (rdata),
        .io_in  (io_in),
        .io_out (io_out),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
        @(negedge clk);
        addr  = a;
        wdata = d;
        len   = l;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] l, output logic [31:0] d);
        addr  = a;
        len   = l;
        rd_en = 1'b1;
        #1;
        d     = rdata;
        rd_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int c = 0; c < NCH; c++) begin
            v = io_out[c*IOW +: IOW];
            n_cmp++;
            if (v !== 32'hA5) begin
                n_fail++;
                $display("FAIL reset_io_out ch%0d: got %h want %h", c, v, 32'hA5);
            end
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
    endtask

    task automatic test_word_write();
        do_write(32'h100, 32'hDEADBEEF, 3'd2);
        n_cmp++;
        if (io_out[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_write ch0: got %h want DEADBEEF", io_out[31:0]);
        end
        n_cmp++;
        if (io_out[63:32] !== 32'hA5) begin
            n_fail++;
            $display("FAIL word_write ch1 untouched: got %h want 000000A5", io_out[63:32]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] v;
        logic [31:0] a_tab [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        logic [2:0]  l_tab [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] e_tab [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDE12, 32'h0000DE12,
                                   32'hDE12BEEF};
        do_write(32'h102, 32'h00000012, 3'd0);
        n_cmp++;
        if (io_out[31:0] !== 32'hDE12BEEF) begin
            n_fail++;
            $display("FAIL sb_lane2: got %h want DE12BEEF", io_out[31:0]);
        end
        for (int k = 0; k < 5; k++) begin
            do_read(a_tab[k], l_tab[k], v);
            n_cmp++;
            if (v !== e_tab[k]) begin
                n_fail++;
                $display("FAIL load addr=%h len=%0d: got %h want %h", a_tab[k], l_tab[k], v,
                         e_tab[k]);
            end
        end
    endtask

    task automatic test_set_clr();
        logic [31:0] v;
        do_write(32'h104, 32'h0000000F, 3'd2);
        do_write(32'h124, 32'h000000F0, 3'd2);
        n_cmp++;
        if (io_out[63:32] !== 32'hFF) begin
            n_fail++;
            $display("FAIL set ch1: got %h want 000000FF", io_out[63:32]);
        end
        do_write(32'h144, 32'h0000003C, 3'd2);
        n_cmp++;
        if (io_out[63:32] !== 32'hC3) begin
            n_fail++;
            $display("FAIL clr ch1: got %h want 000000C3", io_out[63:32]);
        end
        // Byte SET on lane 1 only touches bits 15:8.
        do_write(32'h125, 32'h00000001, 3'd0);
        n_cmp++;
        if (io_out[63:32] !== 32'h1C3) begin
            n_fail++;
            $display("FAIL set_byte ch1: got %h want 000001C3", io_out[63:32]);
        end
        do_read(32'h124, 3'd2, v);
        n_cmp++;
        if (v !== 32'h1C3) begin
            n_fail++;
            $display("FAIL read_set_alias: got %h want 000001C3", v);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] v;
        do_write(32'h101, 32'h0000FFFF, 3'd1);
        n_cmp++;
        if (io_out[31:0] !== 32'hDE12BEEF) begin
            n_fail++;
            $display("FAIL misaligned_sh: got %h want DE12BEEF", io_out[31:0]);
        end
        do_read(32'h101, 3'd2, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned_lw: got %h want 00000000", v);
        end
        do_write(32'h100, 32'h00000000, 3'd3);
        n_cmp++;
        if (io_out[31:0] !== 32'hDE12BEEF) begin
            n_fail++;
            $display("FAIL bad_len_write: got %h want DE12BEEF", io_out[31:0]);
        end
    endtask

    task automatic test_input_event();
        logic [31:0] v;
        @(negedge clk);
        io_in[2*IOW + 5] = 1'b1;
        @(posedge clk);
        #1;
        do_read(32'h168, 3'd2, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL in2_after_1_edge: got %h want 00000000", v);
        end
        @(posedge clk);
        #1;
        do_read(32'h168, 3'd2, v);
        n_cmp++;
        if (v !== 32'h20) begin
            n_fail++;
            $display("FAIL in2_after_2_edges: got %h want 00000020", v);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after_2_edges: got %b want 0", irq);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_after_3_edges: got %b want 1", irq);
        end
        do_read(32'h188, 3'd2, v);
        n_cmp++;
        if (v !== 32'h20) begin
            n_fail++;
            $display("FAIL evt2_set: got %h want 00000020", v);
        end
        do_write(32'h188, 32'h00000020, 3'd2);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after_w1c: got %b want 0", irq);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        @(negedge clk);
        io_in[2*IOW + 6] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        // The rise pulse is live now; the W1C below is sampled on the same edge as the set.
        @(negedge clk);
        addr  = 32'h188;
        wdata = 32'h00000040;
        len   = 3'd2;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        do_read(32'h188, 3'd2, v);
        n_cmp++;
        if (v !== 32'h40) begin
            n_fail++;
            $display("FAIL set_wins evt2: got %h want 00000040", v);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins irq: got %b want 1", irq);
        end
        do_write(32'h188, 32'h00000040, 3'd2);
        do_read(32'h188, 3'd2, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL held_high_no_rearm evt2: got %h want 00000000", v);
        end
    endtask

    task automatic test_reserved_and_miss();
        logic [31:0] v;
        do_write(32'h1C0, 32'h12345678, 3'd2);
        n_cmp++;
        if (io_out[31:0] !== 32'hDE12BEEF) begin
            n_fail++;
            $display("FAIL reserved_write: got %h want DE12BEEF", io_out[31:0]);
        end
        addr  = 32'h1C0;
        len   = 3'd2;
        rd_en = 1'b1;
        #1;
        n_cmp++;
        if (hit !== 1'b1 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_read: got hit=%b rdata=%h want hit=1 rdata=00000000", hit,
                     rdata);
        end
        addr = 32'h280;
        #1;
        n_cmp++;
        if (hit !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL miss_above: got hit=%b rdata=%h want hit=0 rdata=00000000", hit,
                     rdata);
        end
        addr = 32'h0FC;
        #1;
        n_cmp++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_below: got hit=%b want 0", hit);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_rd_wr_same();
        @(negedge clk);
        addr  = 32'h108;
        wdata = 32'h00000055;
        len   = 3'd2;
        rd_en = 1'b1;
        wr_en = 1'b1;
        #1;
        n_cmp++;
        if (rdata !== 32'hA5) begin
            n_fail++;
            $display("FAIL rd_wr_pre_value: got %h want 000000A5", rdata);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        n_cmp++;
        if (io_out[2*IOW +: IOW] !== 32'h55) begin
            n_fail++;
            $display("FAIL rd_wr_post_value ch2: got %h want 00000055", io_out[2*IOW +: IOW]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] v;
        @(negedge clk);
        io_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_irq: got %b want 1", irq);
        end
        @(negedge clk);
        addr  = 32'h100;
        wdata = 32'h11111111;
        len   = 3'd2;
        wr_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (io_out[31:0] !== 32'hA5 || io_out[2*IOW +: IOW] !== 32'hA5) begin
            n_fail++;
            $display("FAIL reset_immediate: got ch0=%h ch2=%h want 000000A5", io_out[31:0],
                     io_out[2*IOW +: IOW]);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq_immediate: got %b want 0", irq);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (io_out[31:0] !== 32'hA5) begin
            n_fail++;
            $display("FAIL write_lost_in_reset: got %h want 000000A5", io_out[31:0]);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        // Inputs still high at release: each produces exactly one event after 3 edges.
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL release_irq_2_edges: got %b want 0", irq);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL release_irq_3_edges: got %b want 1", irq);
        end
        do_read(32'h188, 3'd2, v);
        n_cmp++;
        if (v !== 32'h60) begin
            n_fail++;
            $display("FAIL release_evt2: got %h want 00000060", v);
        end
        do_read(32'h180, 3'd2, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_fail++;
            $display("FAIL release_evt0: got %h want 00000001", v);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        addr   = '0;
        wdata  = '0;
        len    = 3'd2;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        io_in  = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_word_write();
        test_byte_lanes();
        test_set_clr();
        test_misaligned();
        test_input_event();
        test_set_wins();
        test_reserved_and_miss();
        test_rd_wr_same();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Parametrised memory-mapped GPIO controller for the RISC-V SoC, replacing the single-register IO block at the top level. It decodes processor MEM-stage accesses in a window at `BASE_ADDR`. It provides `NUM_CH` output registers with set/clear aliases and `NUM_CH` synchronised input ports with sticky rising-edge event flags and an interrupt line. Reads are RISC-V sub-word aware: byte/half/word, with sign or zero extension.

## Interface
- `WIDTH`, 32: bus data/address width.
- `BASE_ADDR`, 256: first byte address of the window. Must be aligned to window size.
- `NUM_CH`, 4: channel count, power of two, 1..16.
- `IO_WIDTH`, 32: bits per channel, ≤ `WIDTH`.
- `OUT_RESET`, 0: reset value of every OUT register.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in `WIDTH`: byte address, from ALU out.
- `wdata` in `WIDTH`: store data, right-aligned.
- `len` in 3: RISC-V funct3. 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- `rd_en` in 1: load strobe.
- `wr_en` in 1: store strobe.
- `hit` out 1: `addr` inside window (combinational).
- `rdata` out `WIDTH`: load data. 0 unless `rd_en & hit`.
- `io_in` in `NUM_CH*IO_WIDTH`: asynchronous inputs, channel i at `[i*IO_WIDTH +: IO_WIDTH]`.
- `io_out` out `NUM_CH*IO_WIDTH`: registered outputs.
- `irq` out 1: OR of all event bits.

## Operation
- Window size: `32*NUM_CH` bytes.
- Offset: `{region[2:0], idx[log2 NUM_CH-1:0], 2'b00}`, plus byte offset `addr[1:0]`.
- Regions:
  - 0 OUT: read/write.
  - 1 OUT_SET: write-1-sets; reads return OUT.
  - 2 OUT_CLR: write-1-clears; reads return OUT.
  - 3 IN: read-only, synchronised input; writes ignored.
  - 4 EVT: sticky rising-edge flags; write-1-clears.
  - 5..7: reserved. Read 0, writes ignored.
- Write lanes:
  - W: all 4 bytes.
  - H: bytes `{addr[1],0}` and `{addr[1],1}`, taken from `wdata[15:0]`.
  - B: byte `addr[1:0]`, taken from `wdata[7:0]`.
  - Unwritten lanes keep their value. SET/CLR/W1C apply only to enabled lanes.
- Misaligned access (H with `addr[0]=1`, W with `addr[1:0]≠0`): write ignored, read returns 0.
- Read: select the word, shift right by `8*addr[1:0]`, then extend.
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - W is unmodified.
  - Any other `len` value returns 0 and writes are ignored.
- Bits ≥ `IO_WIDTH` of any register: read 0, writes ignored.
- Event bit j of channel i sets on a 0→1 transition of synchronised input bit j. It stays set until a W1C write clears it.
- Same-edge event set and W1C of the same bit: set wins, bit stays 1.
- `rd_en & wr_en` together: the write executes, and `rdata` shows the pre-write value.

## Timing
- Reset (asynchronous assert, synchronous-release behaviour in RTL):
  - `io_out = OUT_RESET` replicated per channel.
  - Synchroniser flops, edge-history flops and EVT registers = 0.
  - `irq = 0`.
- An input already high at reset release produces one event.
- `rdata` and `hit` are combinational, valid in the same cycle as the request (MEM stage, zero wait states).
- A write updates register and `io_out` at the `clk` edge where `wr_en & hit` is sampled.
- Input-to-IN latency: `SYNC_STAGES` edges. Event bit and `irq` rise one edge later (`SYNC_STAGES+1`).
- `irq` is derived from registered EVT state and is glitch-free.
- Reset asserted mid-operation: all state clears immediately; a write sampled in the same cycle is lost.

## Structure
- `gpio_pkg`: region encodings (`REG_OUT`…`REG_EVT`), `len` encodings (`LEN_B`…`LEN_HU`), byte-lane mask function, load-extend function.
- Sub-module `gpio_in_sync`: one per channel, `SYNC_STAGES`-deep synchroniser plus edge detector. Outputs the level and a 1-cycle rise pulse.
- Top `mmio_gpio`: decoder, OUT/EVT register arrays, read mux/extend.
- SoC top ORs `rdata` with data_mem output and gates data_mem CE with `~hit`.

## Test plan
- Reset with `OUT_RESET=32'hA5` → all `io_out` channels = `0xA5`, `irq=0`; W to 0x100 with `0xDEADBEEF` → ch0 `io_out = 0xDEADBEEF` after 1 edge.
- Byte lanes: OUT0 = `0xDEADBEEF`; SB `0x12` to 0x102 → `0xDE12BEEF`. LB at 0x103 → `0xFFFFFFDE`; LBU → `0x000000DE`; LH at 0x102 → `0xFFFFDE12`.
- OUT1 = `0x0F`; SET (0x124) with `0xF0` → `0xFF`; CLR (0x144) with `0x3C` → `0xC3`. SH to 0x101 (misaligned) → OUT0 unchanged; LW 0x101 → 0.
- `io_in` ch2 bit 5 goes 0→1 → IN2 (0x168) reads `0x20` after 2 edges. EVT2 bit 5 and `irq` set after 3 edges. W1C `0x20` to 0x188 → `irq` falls next edge.
- Rising edge coincident with a W1C of the same bit → bit remains 1. Region 6 read → 0. Address 0x180+`32*NUM_CH` → `hit=0`, `rdata=0`.
- Assert `rst_n` low mid-write → no update; all outputs return to reset values immediately.
